// File: rtl/q16_rr_scheduler.sv
// q16_rr_scheduler
// Shares one in-order Q16.16 streaming core among N_REQ requesters.
// Requests are arbitrated round-robin into the core. Each issued sample's
// requester ID goes into an in-order tag FIFO. Each core result is routed
// back to the requester whose tag sits at the FIFO head.
// Both the request path and the response path are combinational. The
// scheduler adds no pipeline stage.
module q16_rr_scheduler #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ*DATA_W-1:0]           req_data,
  output logic                              core_in_valid,
  input  logic                              core_in_ready,
  output logic [DATA_W-1:0]                 core_in_data,
  input  logic                              core_out_valid,
  output logic                              core_out_ready,
  input  logic [DATA_W-1:0]                 core_out_data,
  output logic [N_REQ-1:0]                  rsp_valid,
  input  logic [N_REQ-1:0]                  rsp_ready,
  output logic [DATA_W-1:0]                 rsp_data,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              err_orphan
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  // While a stalled grant is held, the selected requester must not change.
  typedef enum logic {
    LOCK_OPEN,
    LOCK_HELD
  } lock_state_t;

  lock_state_t      lock_state;
  lock_state_t      lock_next;
  logic [ID_W-1:0]  lock_idx;
  logic [ID_W-1:0]  rr_ptr;

  logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [ID_W-1:0]  rr_idx;
  logic             rr_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             in_fire;
  logic             out_fire;
  int               cand;

  assign fifo_full  = (count == CNT_W'(MAX_INFLIGHT));
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];
  assign inflight   = count;

  // Find the first valid requester, starting one past the last grant and wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = ID_W'(cand);
      end
    end
  end

  // A held lock overrides the round-robin search. That keeps the core input stable during a stall.
  assign grant_idx     = (lock_state == LOCK_HELD) ? lock_idx : rr_idx;
  assign core_in_valid = rst_n && (rr_found || (lock_state == LOCK_HELD)) && !fifo_full;
  assign in_fire       = core_in_valid && core_in_ready;

  // An orphan result (FIFO empty) is accepted and dropped. Otherwise, ready follows the head requester.
  assign out_fire      = core_out_valid && core_out_ready && !fifo_empty;

  // Lock next-state: held from an unaccepted offer until the handshake completes.
  always_comb begin
    lock_next = lock_state;
    case (lock_state)
      LOCK_OPEN: if (core_in_valid && !core_in_ready) lock_next = LOCK_HELD;
      LOCK_HELD: if (in_fire)                         lock_next = LOCK_OPEN;
      default:                                        lock_next = LOCK_OPEN;
    endcase
  end

  // Data path and per-requester handshakes; everything is forced low in reset.
  always_comb begin
    req_ready      = '0;
    core_in_data   = '0;
    rsp_valid      = '0;
    rsp_data       = '0;
    core_out_ready = 1'b0;
    if (rst_n) begin
      core_in_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
      rsp_data     = core_out_data;
      if (in_fire) req_ready[grant_idx] = 1'b1;
      if (fifo_empty) begin
        core_out_ready = core_out_valid;
      end else begin
        core_out_ready = rsp_ready[head];
        if (core_out_valid) rsp_valid[head] = 1'b1;
      end
    end
  end

  // Lock state, lock index and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then sees the pre-edge values of the others, whatever the block order.
    if (!rst_n) begin
      lock_state <= LOCK_OPEN;
      lock_idx   <= '0;
      rr_ptr     <= ID_W'(N_REQ - 1);
    end else begin
      lock_state <= lock_next;
      if (lock_state == LOCK_OPEN && lock_next == LOCK_HELD) lock_idx <= grant_idx;
      if (in_fire) rr_ptr <= grant_idx;
    end
  end

  // Tag FIFO pointers, occupancy and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (in_fire)  wr_ptr <= wr_ptr + 1'b1;
      if (out_fire) rd_ptr <= rd_ptr + 1'b1;
      if (in_fire && !out_fire)      count <= count + 1'b1;
      else if (!in_fire && out_fire) count <= count - 1'b1;
      if (core_out_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  // Tag storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. The pointers and count are reset,
    // and an entry is never read before it is written.
    if (in_fire) tag_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: doc/q16_rr_scheduler.md
# q16_rr_scheduler

Round-robin scheduler that shares one Q16.16 streaming compute core (valid/ready in, valid/ready out, in-order, signed 32-bit) among `N_REQ` requester streams. It arbitrates requests into the core, records each issued sample's requester ID in an in-order tag FIFO, and routes each core result back to the requester that issued it. It sits between the requester front-ends and the single shared core instance in the top level.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters. Range 2..16.
- `DATA_W`, 32: sample width, signed Q16.16.
- `MAX_INFLIGHT`, 8: tag FIFO depth, which is the maximum number of samples in the core. Must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, `N_REQ`: per-requester request valid.
- `req_ready`, out, `N_REQ`: per-requester request accept.
- `req_data`, in, `N_REQ*DATA_W`: requester i's sample is at bits `[i*DATA_W +: DATA_W]`.
- `core_in_valid`, out, 1: sample valid toward the core.
- `core_in_ready`, in, 1: core accepts the sample.
- `core_in_data`, out, `DATA_W`: selected sample.
- `core_out_valid`, in, 1: core result valid.
- `core_out_ready`, out, 1: scheduler accepts the result.
- `core_out_data`, in, `DATA_W`: core result.
- `rsp_valid`, out, `N_REQ`: one-hot response valid.
- `rsp_ready`, in, `N_REQ`: per-requester response accept.
- `rsp_data`, out, `DATA_W`: shared response bus, equal to `core_out_data`.
- `inflight`, out, `$clog2(MAX_INFLIGHT)+1`: number of occupied tag FIFO entries.
- `err_orphan`, out, 1: sticky flag. Set when the core produces a result with no outstanding tag.

## Operation

- **Eligibility:** requester i is eligible when `req_valid[i]` is high.
- **Issue condition:** the scheduler may issue only when the tag FIFO is not full, judged on the registered count at the start of the cycle.
- **Grant selection:** `rr_ptr` holds the index of the last requester granted. The grant goes to the first eligible index searched in the order `rr_ptr+1`, `rr_ptr+2`, … wrapping modulo `N_REQ`.
- **Grant lock:** once `core_in_valid` is high and `core_in_ready` is low, `grant_idx` is registered and locked. It stays fixed until the handshake completes, so `core_in_valid` and `core_in_data` are stable during a core stall. Requesters must hold `req_valid` and `req_data` once asserted; this is a protocol rule.
- **Input signals:**
  - `core_in_valid` = (any eligible requester, or lock active) and tag FIFO not full.
  - `core_in_valid` never depends on `core_in_ready`.
  - `core_in_data` = `req_data` slice selected by `grant_idx`.
  - `req_ready[i]` = `core_in_ready` && `core_in_valid` && (`grant_idx` == i).
- **On an input handshake:**
  - Push `grant_idx` into the tag FIFO.
  - Set `rr_ptr` to `grant_idx`.
  - Release the lock.
- **Response routing:**
  - `head` is the tag at the FIFO head.
  - `rsp_valid[i]` = `core_out_valid` && FIFO not empty && `head` == i.
  - `core_out_ready` = FIFO not empty && `rsp_ready[head]`.
  - On an output handshake, pop the FIFO.
- **Orphan result:** if `core_out_valid` is high while the FIFO is empty:
  - `core_out_ready` = 1, so the result is drained and dropped.
  - All `rsp_valid` bits stay 0.
  - `err_orphan` is set and stays set until reset.
- **Simultaneous push and pop:** `inflight` is unchanged. A pop does not free a slot for a push in the same cycle (no full-bypass).
- **Data handling:** no arithmetic is performed on data. Data passes through unmodified.

## Timing

- **Reset** (`rst_n` low at a clock edge):
  - `rr_ptr` = `N_REQ-1`, so requester 0 has first priority.
  - Lock cleared, FIFO emptied, `inflight` = 0, `err_orphan` = 0.
  - During reset, all outputs are forced low: `req_ready`, `core_in_valid`, `core_out_ready`, `rsp_valid`, `core_in_data`, `rsp_data`.
- **Latency:** the request-to-core path is combinational (0 cycles). The core-to-response path is combinational (0 cycles). The scheduler adds no pipeline stage.
- **Throughput:** one issue and one return per cycle.
- **Reset mid-operation:** all tags are discarded. The bench must also reset the core. Results from the core that arrive after reset raise `err_orphan`.
- **Full:** with `inflight` == `MAX_INFLIGHT`, `core_in_valid` = 0 and all `req_ready` = 0.
- **Wrap-around:** the FIFO pointers wrap modulo `MAX_INFLIGHT`. `rr_ptr` wraps modulo `N_REQ`.

## Test plan

- **Reset:** hold reset 5 cycles, then release → all outputs 0 and `inflight` = 0. A single request from requester 2 with data `32'sh0001_0000` issues on the first cycle.
- **Fairness:** all 4 requesters valid continuously, core always ready → grant order 0,1,2,3,0,1,…. Results route to the matching `rsp_valid` bit in the same order.
- **Core stall:** `core_in_ready` low for 3 cycles while requester 1 is granted and requester 0 raises valid → `grant_idx` stays 1 and `core_in_data` is stable. Requester 1 is accepted first, then requester 0.
- **Full FIFO:** core never returns results, 9 requests offered → exactly 8 accepted and `inflight` = 8. `core_in_valid` stays 0 until one result is popped, after which issue resumes one cycle later.
- **Response backpressure:** the head tag's `rsp_ready` is held low → `core_out_ready` = 0. Ready on other requesters has no effect.
- **Orphan result:** `core_out_valid` pulses with an empty FIFO → `err_orphan` = 1 and stays 1 through later traffic. No `rsp_valid` bit is asserted.
